// File: rtl/spmmio_arb_pkg.sv
// spmmio_arb_pkg: shared definitions for the two-master MMIO arbiter.
//   NMASTER        number of masters sharing the peripheral
//   ADR_W/SEL_W    peripheral register address and byte-select widths
//   DATA_W         peripheral data width
//   state_e        access FSM encoding (IDLE -> ACCESS -> ACK -> IDLE)
package spmmio_arb_pkg;

  localparam int NMASTER = 2;
  localparam int ADR_W   = 4;
  localparam int SEL_W   = 4;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/spmmio_arb_rr.sv
// spmmio_arb_rr: combinational two-input round-robin picker.
//   elig_i     eligible-master mask
//   last_i     index of the master granted most recently
//   gnt_vld_o  at least one master is eligible
//   gnt_idx_o  index of the winning master
module spmmio_arb_rr (
  input  logic [1:0] elig_i,
  input  logic       last_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_vld_o = |elig_i;
    gnt_idx_o = 1'b0;
    case (elig_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      // Contention: the master that did not win last time goes next.
      2'b11:   gnt_idx_o = ~last_i;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/spmmio_arb.sv
// spmmio_arb: arbitrates two masters onto one simple MMIO peripheral port.
// Each access takes three cycles: IDLE (arbitrate), ACCESS (cs high, the
// peripheral answers combinationally on q), ACK (m_ack pulse, m_q updated).
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   m_req/m_lock/m_we   per-master request, bus-lock, write enable (bit i)
//   m_adr/m_sel         per-master 4-bit address / byte selects (slice i)
//   m_d                 per-master 32-bit write data (slice i)
//   m_ack, m_q          per-master completion pulse and read data
//   adr, cs, sel, we, d peripheral request (registered)
//   q                   peripheral read data
//
// Build option: define SPMMIO_ARB_LOCK_EN to honour m_lock. A master that
// finishes an access with its lock bit high becomes the only eligible master
// until one of its accesses finishes with the lock bit low. When undefined,
// m_lock is ignored and no lock state is built.
module spmmio_arb
  import spmmio_arb_pkg::*;
#(
  parameter int RESET_LAST = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NMASTER-1:0]        m_req,
  input  logic [NMASTER-1:0]        m_lock,
  input  logic [NMASTER*ADR_W-1:0]  m_adr,
  input  logic [NMASTER*SEL_W-1:0]  m_sel,
  input  logic [NMASTER-1:0]        m_we,
  input  logic [NMASTER*DATA_W-1:0] m_d,
  output logic [NMASTER-1:0]        m_ack,
  output logic [NMASTER*DATA_W-1:0] m_q,
  output logic [ADR_W-1:0]          adr,
  output logic                      cs,
  output logic [SEL_W-1:0]          sel,
  output logic                      we,
  output logic [DATA_W-1:0]         d,
  input  logic [DATA_W-1:0]         q
);

  localparam logic LAST_RST = 1'(RESET_LAST);

  state_e                    state_q;
  logic                      cs_q, we_q;
  logic [ADR_W-1:0]          adr_q;
  logic [SEL_W-1:0]          sel_q;
  logic [DATA_W-1:0]         d_q;
  logic [NMASTER-1:0]        ack_q;
  logic [NMASTER*DATA_W-1:0] mq_q;
  logic                      gnt_q;
  logic                      last_q;

  logic [NMASTER-1:0]        elig_d;
  logic                      gnt_vld;
  logic                      gnt_idx;

`ifdef SPMMIO_ARB_LOCK_EN
  logic lock_vld_q;
  logic lock_own_q;

  // While a lock is held only the owner may be granted.
  always_comb begin
    elig_d = m_req;
    if (lock_vld_q) elig_d = m_req & (lock_own_q ? 2'b10 : 2'b01);
  end

  // Lock state follows the lock bit of the access currently in ACCESS;
  // only the owner can be in ACCESS while locked, so gnt_q is the owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
    end else if (state_q == ST_ACCESS) begin
      if (m_lock[gnt_q]) begin
        lock_vld_q <= 1'b1;
        lock_own_q <= gnt_q;
      end else begin
        lock_vld_q <= 1'b0;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^m_lock;
  assign elig_d      = m_req;
`endif

  spmmio_arb_rr u_rr (
    .elig_i    (elig_d),
    .last_i    (last_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      d_q     <= '0;
      ack_q   <= '0;
      mq_q    <= '0;
      gnt_q   <= 1'b0;
      last_q  <= LAST_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            state_q <= ST_ACCESS;
            cs_q    <= 1'b1;
            we_q    <= m_we[gnt_idx];
            adr_q   <= m_adr[gnt_idx*ADR_W +: ADR_W];
            sel_q   <= m_sel[gnt_idx*SEL_W +: SEL_W];
            d_q     <= m_d[gnt_idx*DATA_W +: DATA_W];
            gnt_q   <= gnt_idx;
            last_q  <= gnt_idx;
          end
        end
        ST_ACCESS: begin
          // q is valid now because adr has been stable since the grant edge.
          state_q                          <= ST_ACK;
          cs_q                             <= 1'b0;
          ack_q[gnt_q]                     <= 1'b1;
          mq_q[gnt_q*DATA_W +: DATA_W]     <= q;
        end
        ST_ACK: begin
          // Requests seen here are ignored; the master may still be
          // holding req for the access just acknowledged.
          state_q <= ST_IDLE;
          ack_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cs    = cs_q;
  assign we    = we_q;
  assign adr   = adr_q;
  assign sel   = sel_q;
  assign d     = d_q;
  assign m_ack = ack_q;
  assign m_q   = mq_q;

endmodule

// File: tb/tb_spmmio_arb.sv
module tb_spmmio_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_lock = '0;
  logic [7:0]  m_adr = '0;
  logic [7:0]  m_sel = '0;
  logic [1:0]  m_we = '0;
  logic [63:0] m_d = '0;
  logic [1:0]  m_ack;
  logic [63:0] m_q;
  logic [3:0]  adr;
  logic        cs;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] d;
  logic [31:0] q;

  int checks = 0;
  int errors = 0;

  // Peripheral: fixed register file, address 0 reads 3, others C0DE_000<adr>.
  assign q = (adr == 4'd0) ? 32'h0000_0003 : (32'hC0DE_0000 | {28'd0, adr});

  always #5 clk = ~clk;

  spmmio_arb dut (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_lock(m_lock),
    .m_adr(m_adr), .m_sel(m_sel), .m_we(m_we), .m_d(m_d),
    .m_ack(m_ack), .m_q(m_q), .adr(adr), .cs(cs), .sel(sel), .we(we),
    .d(d), .q(q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_req = '0; m_lock = '0;
    #1 reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    m_req = '0;
    #2 reset_n = 1'b0;
    tick(); tick();
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL reset_cs got %0b exp 0", cs); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", we); end
    checks++; if (adr !== 4'd0) begin errors++; $display("FAIL reset_adr got %0h exp 0", adr); end
    checks++; if (sel !== 4'd0) begin errors++; $display("FAIL reset_sel got %0h exp 0", sel); end
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_d got %0h exp 0", d); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %0b exp 0", m_ack); end
    checks++; if (m_q !== 64'd0) begin errors++; $display("FAIL reset_mq got %0h exp 0", m_q); end
    reset_n = 1'b1;
    tick();
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL idle_cs got %0b exp 0", cs); end
  endtask

  task automatic test_write();
    m_adr[3:0] = 4'd1; m_sel[3:0] = 4'b0001; m_we[0] = 1'b1;
    m_d[31:0] = 32'h0000_000A; m_req[0] = 1'b1;
    tick();
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL wr_cs got %0b exp 1", cs); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL wr_we got %0b exp 1", we); end
    checks++; if (d !== 32'h0000_000A) begin errors++; $display("FAIL wr_d got %0h exp a", d); end
    checks++; if (adr !== 4'd1) begin errors++; $display("FAIL wr_adr got %0h exp 1", adr); end
    checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL wr_sel got %0b exp 0001", sel); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL wr_ack_early got %0b exp 00", m_ack); end
    tick();
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL wr_cs_drop got %0b exp 0", cs); end
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL wr_ack got %0b exp 01", m_ack); end
    checks++; if (m_q[31:0] !== 32'hC0DE_0001) begin errors++; $display("FAIL wr_mq0 got %0h exp c0de0001", m_q[31:0]); end
    m_req[0] = 1'b0; m_we[0] = 1'b0;
    tick();
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL wr_ack_end got %0b exp 00", m_ack); end
    checks++; if (d !== 32'h0000_000A) begin errors++; $display("FAIL wr_d_hold got %0h exp a", d); end
  endtask

  task automatic test_read();
    m_adr[7:4] = 4'd0; m_sel[7:4] = 4'hF; m_we[1] = 1'b0;
    m_d[63:32] = 32'hDEAD_BEEF; m_req[1] = 1'b1;
    tick();
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rd_cs got %0b exp 1", cs); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rd_we got %0b exp 0", we); end
    checks++; if (adr !== 4'd0) begin errors++; $display("FAIL rd_adr got %0h exp 0", adr); end
    checks++; if (sel !== 4'hF) begin errors++; $display("FAIL rd_sel got %0h exp f", sel); end
    tick();
    checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL rd_ack got %0b exp 10", m_ack); end
    checks++; if (m_q[63:32] !== 32'h0000_0003) begin errors++; $display("FAIL rd_mq1 got %0h exp 3", m_q[63:32]); end
    checks++; if (m_q[31:0] !== 32'hC0DE_0001) begin errors++; $display("FAIL rd_mq0_keep got %0h exp c0de0001", m_q[31:0]); end
    m_req[1] = 1'b0;
    tick();
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rd_ack_end got %0b exp 00", m_ack); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ack [12] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                                 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    logic       exp_cs  [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    m_adr = {4'd3, 4'd2}; m_we = 2'b00; m_req = 2'b11;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (m_ack !== exp_ack[c]) begin errors++; $display("FAIL rr_ack[%0d] got %0b exp %0b", c, m_ack, exp_ack[c]); end
      checks++;
      if (cs !== exp_cs[c]) begin errors++; $display("FAIL rr_cs[%0d] got %0b exp %0b", c, cs, exp_cs[c]); end
    end
    m_req = 2'b00;
    checks++; if (m_q !== {32'hC0DE_0003, 32'hC0DE_0002}) begin errors++; $display("FAIL rr_mq got %0h exp c0de0003c0de0002", m_q); end
    tick(); tick(); tick();
  endtask

  task automatic test_lock();
    logic [1:0] gseq [5];
    logic       exp_seq [5];
    int n_gnt = 0;
    int m0_acks = 0;
    int cyc = 0;
`ifdef SPMMIO_ARB_LOCK_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 5; i++) gseq[i] = 2'b11;
    do_reset();
    m_adr = {4'd5, 4'd4}; m_we = 2'b00; m_req = 2'b11; m_lock = 2'b01;
    while (cyc < 60 && n_gnt < 5) begin
      tick();
      cyc++;
      if (cs) begin
        gseq[n_gnt] = (adr == 4'd5) ? 2'b01 : 2'b00;
        n_gnt++;
      end
      if (m_ack[0]) begin
        m0_acks++;
        if (m0_acks == 3) m_lock[0] = 1'b0;
        if (m0_acks == 4) m_req[0] = 1'b0;
      end
    end
    checks++;
    if (n_gnt < 5) begin errors++; $display("FAIL lock_timeout got %0d grants exp 5", n_gnt); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gseq[i] !== {1'b0, exp_seq[i]}) begin
        errors++; $display("FAIL lock_grant[%0d] got %0d exp %0d", i, gseq[i], exp_seq[i]);
      end
    end
    m_req = 2'b00; m_lock = 2'b00;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_adr = {4'd6, 4'd7}; m_we = 2'b00; m_req = 2'b10;
    tick();
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rm_cs_pre got %0b exp 1", cs); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL rm_cs_async got %0b exp 0", cs); end
    checks++; if (adr !== 4'd0) begin errors++; $display("FAIL rm_adr got %0h exp 0", adr); end
    checks++; if (m_q !== 64'd0) begin errors++; $display("FAIL rm_mq got %0h exp 0", m_q); end
    m_req = 2'b00;
    tick(); tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (m_ack !== 2'b00) begin errors++; $display("FAIL rm_noack[%0d] got %0b exp 00", c, m_ack); end
    end
    m_req = 2'b11;
    tick();
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rm_cs_post got %0b exp 1", cs); end
    checks++; if (adr !== 4'd7) begin errors++; $display("FAIL rm_first_grant adr got %0h exp 7", adr); end
    tick();
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL rm_ack_post got %0b exp 01", m_ack); end
    m_req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_lock();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
